// File: rtl/recovery_sequencer.sv
// Recovery sequencer: drives clear / acquire / lock / holdoff / fault control of the
// recovery datapath with bounded retries and optional source swapping between attempts.
module recovery_sequencer #(
    parameter int CLEAR_CYCLES  = 4,
    parameter int TIMEOUT_WIDTH = 16,
    parameter int RETRY_WIDTH   = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     source_pref_i,
    input  logic                     auto_swap_en_i,
    input  logic [TIMEOUT_WIDTH-1:0] acquire_timeout_i,
    input  logic [TIMEOUT_WIDTH-1:0] holdoff_i,
    input  logic [RETRY_WIDTH-1:0]   max_retries_i,
    input  logic                     fully_locked_in_i,
    input  logic                     excessive_drift_violation_i,
    input  logic                     bandpass_violation_i,
    output logic                     recovery_en_o,
    output logic                     clear_state_o,
    output logic                     source_select_o,
    output logic [2:0]               state_o,
    output logic                     locked_o,
    output logic                     fault_o,
    output logic                     lock_lost_o,
    output logic [RETRY_WIDTH-1:0]   retry_count_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_ACQUIRE = 3'd2;
    localparam logic [2:0] S_LOCKED  = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;
    localparam logic [7:0] CLR_LAST  = 8'(CLEAR_CYCLES - 1);

    logic [2:0]               r_state;
    logic [TIMEOUT_WIDTH-1:0] r_timer;
    logic [7:0]               r_clr_cnt;
    logic [RETRY_WIDTH-1:0]   r_retry;
    logic                     r_source;
    logic                     r_rec_en;
    logic                     r_clear;
    logic                     r_locked;
    logic                     r_fault;
    logic                     r_lock_lost;

    logic [2:0]               w_state_nxt;
    logic                     w_retry_clr;
    logic                     w_retry_inc;
    logic                     w_load_src;
    logic                     w_swap;
    logic                     w_lost;
    logic                     w_acq_timeout;
    logic [TIMEOUT_WIDTH-1:0] w_hold_last;
    logic [RETRY_WIDTH-1:0]   w_retry_nxt;
    logic                     w_source_nxt;
    logic                     w_rec_en_nxt;
    logic                     w_clear_nxt;
    logic                     w_locked_nxt;
    logic                     w_fault_nxt;

    // Timeout fires as the acquire_timeout_i-th ACQUIRE cycle ends; >= tolerates a lowered budget.
    assign w_acq_timeout = (acquire_timeout_i != '0) &&
                           (r_timer >= acquire_timeout_i - TIMEOUT_WIDTH'(1));
    assign w_hold_last   = (holdoff_i == '0) ? '0 : holdoff_i - TIMEOUT_WIDTH'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_clr_cnt   <= '0;
            r_retry     <= '0;
            r_source    <= 1'b0;
            r_rec_en    <= 1'b0;
            r_clear     <= 1'b0;
            r_locked    <= 1'b0;
            r_fault     <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_retry     <= w_retry_nxt;
            r_source    <= w_source_nxt;
            r_rec_en    <= w_rec_en_nxt;
            r_clear     <= w_clear_nxt;
            r_locked    <= w_locked_nxt;
            r_fault     <= w_fault_nxt;
            r_lock_lost <= w_lost;
            if (w_state_nxt != r_state || abort_i) begin
                r_timer   <= '0;
                r_clr_cnt <= '0;
            end else begin
                if (r_timer != '1)
                    r_timer <= r_timer + TIMEOUT_WIDTH'(1);
                if (r_clr_cnt != '1)
                    r_clr_cnt <= r_clr_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retry_clr = 1'b0;
        w_retry_inc = 1'b0;
        w_load_src  = 1'b0;
        w_swap      = 1'b0;
        w_lost      = 1'b0;
        if (abort_i) begin
            w_state_nxt = S_IDLE;
            w_retry_clr = 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_FAULT: begin
                    if (start_i) begin
                        w_state_nxt = S_CLEAR;
                        w_retry_clr = 1'b1;
                        w_load_src  = 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt >= CLR_LAST)
                        w_state_nxt = S_ACQUIRE;
                end
                S_ACQUIRE: begin
                    // Lock wins over a coincident failure; bandpass flags are ignored while settling.
                    if (fully_locked_in_i)
                        w_state_nxt = S_LOCKED;
                    else if (excessive_drift_violation_i || w_acq_timeout)
                        w_state_nxt = S_HOLDOFF;
                end
                S_LOCKED: begin
                    if (!fully_locked_in_i || excessive_drift_violation_i || bandpass_violation_i) begin
                        w_state_nxt = S_HOLDOFF;
                        w_lost      = 1'b1;
                    end
                end
                S_HOLDOFF: begin
                    if (r_retry >= max_retries_i) begin
                        w_state_nxt = S_FAULT;
                    end else if (r_timer >= w_hold_last) begin
                        w_state_nxt = S_CLEAR;
                        w_retry_inc = 1'b1;
                        w_swap      = auto_swap_en_i;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rec_en_nxt = (w_state_nxt == S_ACQUIRE) || (w_state_nxt == S_LOCKED);
        w_clear_nxt  = (w_state_nxt == S_CLEAR);
        w_locked_nxt = (w_state_nxt == S_LOCKED);
        w_fault_nxt  = (w_state_nxt == S_FAULT);
        w_source_nxt = r_source;
        if (w_load_src)
            w_source_nxt = source_pref_i;
        else if (w_swap)
            w_source_nxt = ~r_source;
        w_retry_nxt = r_retry;
        if (w_retry_clr)
            w_retry_nxt = '0;
        else if (w_retry_inc && r_retry != '1)
            w_retry_nxt = r_retry + RETRY_WIDTH'(1);
    end

    assign state_o         = r_state;
    assign recovery_en_o   = r_rec_en;
    assign clear_state_o   = r_clear;
    assign source_select_o = r_source;
    assign locked_o        = r_locked;
    assign fault_o         = r_fault;
    assign lock_lost_o     = r_lock_lost;
    assign retry_count_o   = r_retry;

endmodule

// File: tb/tb_recovery_sequencer.sv
// Bench for recovery_sequencer: directed scenarios push expected state entries into a
// queue; a monitor pops one per observed state change and checks outputs and dwell time.
module tb_recovery_sequencer;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_ACQUIRE = 3'd2;
    localparam logic [2:0] S_LOCKED  = 3'd3;
    localparam logic [2:0] S_HOLDOFF = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start, abort, pref, swap_en, lock, drift, bp;
    logic [15:0] timeout, holdoff;
    logic [3:0]  max_r;
    logic        rec_en, clr, src, locked, fault, lost;
    logic [2:0]  state;
    logic [3:0]  retry;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0] st;
        logic [3:0] retry;
        logic       src;
        logic       ll;
        int         dwell;
    } exp_t;
    exp_t q[$];

    recovery_sequencer dut (
        .clk_i                       (clk),
        .rst_ni                      (rst_n),
        .start_i                     (start),
        .abort_i                     (abort),
        .source_pref_i               (pref),
        .auto_swap_en_i              (swap_en),
        .acquire_timeout_i           (timeout),
        .holdoff_i                   (holdoff),
        .max_retries_i               (max_r),
        .fully_locked_in_i           (lock),
        .excessive_drift_violation_i (drift),
        .bandpass_violation_i        (bp),
        .recovery_en_o               (rec_en),
        .clear_state_o               (clr),
        .source_select_o             (src),
        .state_o                     (state),
        .locked_o                    (locked),
        .fault_o                     (fault),
        .lock_lost_o                 (lost),
        .retry_count_o               (retry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic ex(input logic [2:0] st, input int r, input logic s, input logic ll, input int dw);
        exp_t e;
        e.st = st; e.retry = 4'(r); e.src = s; e.ll = ll; e.dwell = dw;
        q.push_back(e);
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget);
        int n = 0;
        while (state !== st && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (state !== st) begin
            tests++;
            fails++;
            $display("FAIL wait_s%0d: state %0d after %0d cycles", st, state, budget);
        end
    endtask

    // Monitor: one expectation consumed per state change seen on the falling edge.
    initial begin : monitor
        logic [2:0]  last;
        int          dwell;
        exp_t        e;
        logic [12:0] act;
        logic [12:0] req;
        last  = S_IDLE;
        dwell = 0;
        forever begin
            @(negedge clk);
            if (state !== last) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_transition: state %0d with nothing expected", state);
                end else begin
                    e   = q.pop_front();
                    act = {state, rec_en, clr, src, locked, fault, lost, retry};
                    req = {e.st, (e.st == S_ACQUIRE) || (e.st == S_LOCKED), e.st == S_CLEAR,
                           e.src, e.st == S_LOCKED, e.st == S_FAULT, e.ll, e.retry};
                    chk($sformatf("entry_s%0d", e.st), 32'(act), 32'(req));
                    if (e.dwell >= 0)
                        chk($sformatf("dwell_before_s%0d", e.st), 32'(dwell), 32'(e.dwell));
                end
                dwell = 1;
                last  = state;
            end else begin
                dwell++;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 0; abort = 0; pref = 0; swap_en = 0; lock = 0; drift = 0; bp = 0;
        timeout = 16'd0; holdoff = 16'd3; max_r = 4'd3;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'(S_IDLE));
        chk("rst_ctrl", 32'({rec_en, clr, src}), 32'd0);
        chk("rst_flags", 32'({locked, fault, lost}), 32'd0);
        chk("rst_retry", 32'(retry), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Lock 10 cycles into ACQUIRE, bandpass ignored while acquiring, then loss of lock.
        ex(S_CLEAR, 0, 0, 0, -1); ex(S_ACQUIRE, 0, 0, 0, 4); ex(S_LOCKED, 0, 0, 0, 10);
        start = 1; @(negedge clk); start = 0;
        wait_state(S_ACQUIRE, 20);
        repeat (4) @(negedge clk);
        bp = 1; @(negedge clk); bp = 0;
        repeat (4) @(negedge clk);
        lock = 1;
        wait_state(S_LOCKED, 5);
        repeat (2) @(negedge clk);
        ex(S_HOLDOFF, 0, 0, 1, -1); ex(S_CLEAR, 1, 0, 0, 3); ex(S_ACQUIRE, 1, 0, 0, 4);
        ex(S_LOCKED, 1, 0, 0, 1);
        bp = 1; @(negedge clk); bp = 0;
        chk("lock_lost_pulse", 32'(lost), 32'd1);
        chk("rec_en_in_holdoff", 32'(rec_en), 32'd0);
        @(negedge clk);
        chk("lock_lost_single", 32'(lost), 32'd0);
        wait_state(S_LOCKED, 30);
        ex(S_IDLE, 0, 0, 0, -1);
        abort = 1; @(negedge clk); abort = 0; lock = 0;
        wait_state(S_IDLE, 3);

        // Never lock: two retries with source swapping, then FAULT; abort+start in FAULT.
        timeout = 16'd20; holdoff = 16'd5; max_r = 4'd2; swap_en = 1; pref = 0;
        ex(S_CLEAR, 0, 0, 0, -1); ex(S_ACQUIRE, 0, 0, 0, 4); ex(S_HOLDOFF, 0, 0, 0, 20);
        ex(S_CLEAR, 1, 1, 0, 5);  ex(S_ACQUIRE, 1, 1, 0, 4); ex(S_HOLDOFF, 1, 1, 0, 20);
        ex(S_CLEAR, 2, 0, 0, 5);  ex(S_ACQUIRE, 2, 0, 0, 4); ex(S_HOLDOFF, 2, 0, 0, 20);
        ex(S_FAULT, 2, 0, 0, 1);
        start = 1; @(negedge clk); start = 0;
        wait_state(S_FAULT, 200);
        repeat (2) @(negedge clk);
        chk("fault_held", 32'(fault), 32'd1);
        ex(S_IDLE, 0, 0, 0, -1);
        abort = 1; start = 1; @(negedge clk); abort = 0; start = 0;
        wait_state(S_IDLE, 3);

        // Lock on the final timeout cycle wins; lock drop; async reset mid-ACQUIRE.
        swap_en = 0; pref = 1;
        ex(S_CLEAR, 0, 1, 0, -1); ex(S_ACQUIRE, 0, 1, 0, 4); ex(S_LOCKED, 0, 1, 0, 20);
        start = 1; @(negedge clk); start = 0;
        wait_state(S_ACQUIRE, 10);
        repeat (19) @(negedge clk);
        lock = 1;
        wait_state(S_LOCKED, 3);
        repeat (2) @(negedge clk);
        ex(S_HOLDOFF, 0, 1, 1, -1); ex(S_CLEAR, 1, 1, 0, 5); ex(S_ACQUIRE, 1, 1, 0, 4);
        ex(S_IDLE, 0, 0, 0, -1);
        lock = 0;
        wait_state(S_ACQUIRE, 20);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_outputs", 32'({state, rec_en, clr, src, locked, fault, lost, retry}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Drift failure, start ignored in ACQUIRE, zero holdoff, retry limit, restart, abort in CLEAR.
        timeout = 16'd0; holdoff = 16'd0; max_r = 4'd1; pref = 0;
        ex(S_CLEAR, 0, 0, 0, -1); ex(S_ACQUIRE, 0, 0, 0, 4); ex(S_HOLDOFF, 0, 0, 0, 3);
        ex(S_CLEAR, 1, 0, 0, 1);  ex(S_ACQUIRE, 1, 0, 0, 4); ex(S_HOLDOFF, 1, 0, 0, 1);
        ex(S_FAULT, 1, 0, 0, 1);
        start = 1; @(negedge clk); start = 0;
        wait_state(S_ACQUIRE, 10);
        start = 1; @(negedge clk); start = 0;
        @(negedge clk);
        drift = 1; @(negedge clk); drift = 0;
        wait_state(S_ACQUIRE, 10);
        drift = 1; @(negedge clk); drift = 0;
        wait_state(S_FAULT, 5);
        pref = 1;
        ex(S_CLEAR, 0, 1, 0, -1); ex(S_IDLE, 0, 1, 0, 1);
        start = 1; @(negedge clk); start = 0;
        abort = 1; @(negedge clk); abort = 0;
        repeat (3) @(negedge clk);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
